alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 30 +++
 rtl/alu_sequencer.sv | 135 +++++++++++++
 tb/tb_alu_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared sequencer definitions: FSM state encoding, ALU opcode constants and decode helpers.
// Pure declarations; no logic, no latency, no flow control of its own.
package alu_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_MULWAIT,
      S_IOWAIT,
      S_EXEC,
      S_HALT
   } state_t;

   localparam logic [7:0]  OP_ADD     = 8'hF8;
   localparam logic [7:0]  OP_SUB     = 8'hF9;
   localparam logic [7:0]  OP_INC     = 8'hFA;
   localparam logic [7:0]  OP_DEC     = 8'hFB;
   localparam logic [7:0]  OP_IN      = 8'hFC;
   localparam logic [7:0]  OP_OUT     = 8'hFD;
   localparam logic [7:0]  OP_MUL     = 8'hFE;
   localparam logic [15:0] INSTR_HALT = 16'h0000;

   localparam int MUL_CNT_W = 4;

   function automatic logic is_io_op(input logic [7:0] op);
      return (op == OP_IN) || (op == OP_OUT);
   endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Instruction sequencer for a 16-bit ALU: fetch, decode, multiply settle or I/O handshake wait, one-cycle execute.
// 3 cycles per plain instruction with zero-wait memory, 3+MUL_WAIT per multiply; fetch and I/O waits stall without bound.
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int MUL_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [15:0]       imem_data,
   output logic [15:0]       instr,
   output logic              exec1,
   input  logic              carryen,
   input  logic              carryout,
   output logic              carrystatus,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              out_ready,
   output logic              out_valid,
   output logic              halted
);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [ADDR_W-1:0]      r_pc;
   logic [15:0]            r_instr;
   logic                   r_carry;
   logic [MUL_CNT_W-1:0]   r_mul_cnt;

   logic [7:0]             w_op;
   logic                   w_fetch_done;
   logic                   w_mul_done;
   logic                   w_io_go;
   logic                   w_in_exec;

   assign w_op         = r_instr[15:8];
   assign w_fetch_done = (r_state == S_FETCH) && imem_ack;
   assign w_mul_done   = (r_mul_cnt == MUL_CNT_W'(MUL_WAIT - 1));
   assign w_io_go      = (w_op == OP_IN) ? in_valid : out_ready;
   assign w_in_exec    = (r_state == S_EXEC);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (run) begin
               w_state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            if (imem_ack) begin
               w_state_nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            if (r_instr == INSTR_HALT) begin
               w_state_nxt = S_HALT;
            end else if (w_op == OP_MUL) begin
               w_state_nxt = S_MULWAIT;
            end else if (is_io_op(w_op)) begin
               w_state_nxt = S_IOWAIT;
            end else begin
               w_state_nxt = S_EXEC;
            end
         end
         S_MULWAIT: begin
            if (w_mul_done) begin
               w_state_nxt = S_EXEC;
            end
         end
         S_IOWAIT: begin
            if (w_io_go) begin
               w_state_nxt = S_EXEC;
            end
         end
         // run is only looked at here, so a drop mid-instruction lets it finish
         S_EXEC: begin
            w_state_nxt = run ? S_FETCH : S_IDLE;
         end
         S_HALT: begin
            w_state_nxt = S_HALT;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // instr only loads on a FETCH ack, so it is frozen from DECODE through EXEC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc      <= '0;
         r_instr   <= '0;
         r_carry   <= 1'b0;
         r_mul_cnt <= '0;
      end else begin
         if (w_fetch_done) begin
            r_instr <= imem_data;
            r_pc    <= r_pc + ADDR_W'(1);
         end
         if (w_in_exec && carryen) begin
            r_carry <= carryout;
         end
         if (r_state == S_MULWAIT) begin
            r_mul_cnt <= r_mul_cnt + MUL_CNT_W'(1);
         end else begin
            r_mul_cnt <= '0;
         end
      end
   end

   // Pure state decodes: nothing here sees in_valid, out_ready or imem_ack
   assign imem_req    = (r_state == S_FETCH);
   assign imem_addr   = r_pc;
   assign instr       = r_instr;
   assign exec1       = w_in_exec;
   assign in_ready    = w_in_exec && (w_op == OP_IN);
   assign out_valid   = w_in_exec && (w_op == OP_OUT);
   assign carrystatus = r_carry;
   assign halted      = (r_state == S_HALT);

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: transaction-timing reference model checked every cycle, directed scenarios, randomized run.
module tb_alu_sequencer;

   localparam int AW = 8;
   localparam int MW = 4;
   localparam int M_IDLE  = 0;
   localparam int M_FETCH = 1;
   localparam int M_BUSY  = 2;
   localparam int M_HALT  = 3;

   logic          clk;
   logic          rst_n;
   logic          run;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack;
   logic [15:0]   imem_data;
   logic [15:0]   instr;
   logic          exec1;
   logic          carryen;
   logic          carryout;
   logic          carrystatus;
   logic          in_valid;
   logic          in_ready;
   logic          out_ready;
   logic          out_valid;
   logic          halted;

   alu_sequencer #(.ADDR_W(AW), .MUL_WAIT(MW)) dut (
      .clk(clk), .rst_n(rst_n), .run(run),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
      .instr(instr), .exec1(exec1), .carryen(carryen), .carryout(carryout), .carrystatus(carrystatus),
      .in_valid(in_valid), .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid),
      .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // stimulus controls
   logic [15:0] mem [256];
   bit  rand_mode = 1'b0;
   bit  f_run = 1'b1, f_in_valid = 1'b1, f_out_ready = 1'b1, f_carryen = 1'b0, f_carryout = 1'b0;
   int  ack_pct = 100;
   int  spur_pct = 0;

   // observation logs (DUT-side, for literal checks)
   int  exec_q[$];
   int  inrdy_q[$];
   int  ovld_q[$];
   int  fetch_q[$];
   int  first_req = -1;
   int  iv_rise = -1;
   int  or_rise = -1;
   int  req_cnt = 0;

   task automatic clear_logs();
      exec_q.delete(); inrdy_q.delete(); ovld_q.delete(); fetch_q.delete();
      first_req = -1; iv_rise = -1; or_rise = -1;
   endtask

   // input driver and instruction memory responder
   initial begin
      run = 1'b0; in_valid = 1'b0; out_ready = 1'b0; carryen = 1'b0; carryout = 1'b0;
      imem_ack = 1'b0; imem_data = 16'h0;
      forever begin
         @(posedge clk);
         #1;
         if (rand_mode) begin
            run       = ($urandom_range(0, 9) != 0);
            in_valid  = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 2) == 0);
            carryen   = 1'($urandom_range(0, 1));
            carryout  = 1'($urandom_range(0, 1));
         end else begin
            run = f_run; in_valid = f_in_valid; out_ready = f_out_ready;
            carryen = f_carryen; carryout = f_carryout;
         end
         if (imem_req) begin
            imem_ack  = ($urandom_range(0, 99) < ack_pct);
            imem_data = mem[imem_addr];
         end else begin
            imem_ack  = ($urandom_range(0, 99) < spur_pct);
            imem_data = 16'($urandom);
         end
      end
   end

   // Reference model: an instruction accepted at cycle t executes at t+2 (plain),
   // t+2+MW (multiply), the cycle after its handshake is first seen from t+2 on (I/O),
   // or halts the machine from t+2 (0x0000).
   int          cyc = 0;
   int          md = M_IDLE;
   logic [7:0]  m_pc = 8'h0;
   logic [15:0] m_instr = 16'h0;
   logic        m_carry = 1'b0;
   int          exec_at = -1;
   int          halt_at = -1;
   int          io_from = -1;
   bit          io_pend = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            chk("rst_imem_req", imem_req, 0);
            chk("rst_exec1", exec1, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_halted", halted, 0);
            chk("rst_carrystatus", carrystatus, 0);
            chk("rst_instr", instr, 0);
            chk("rst_imem_addr", imem_addr, 0);
            md = M_IDLE; m_pc = 8'h0; m_instr = 16'h0; m_carry = 1'b0;
            exec_at = -1; halt_at = -1; io_pend = 1'b0;
         end else begin
            logic       e_exec;
            logic [7:0] op;
            op     = m_instr[15:8];
            e_exec = (md == M_BUSY) && (cyc == exec_at);
            chk("imem_req", imem_req, md == M_FETCH);
            chk("imem_addr", imem_addr, m_pc);
            chk("instr", instr, m_instr);
            chk("exec1", exec1, e_exec);
            chk("in_ready", in_ready, e_exec && (op == 8'hFC));
            chk("out_valid", out_valid, e_exec && (op == 8'hFD));
            chk("carrystatus", carrystatus, m_carry);
            chk("halted", halted, md == M_HALT);

            if (imem_req) begin
               req_cnt++;
               if (first_req < 0) first_req = cyc;
               if (imem_ack) fetch_q.push_back(int'(imem_addr));
            end
            if (exec1) exec_q.push_back(cyc);
            if (in_ready) inrdy_q.push_back(cyc);
            if (out_valid) ovld_q.push_back(cyc);
            if (in_valid && iv_rise < 0) iv_rise = cyc;
            if (out_ready && or_rise < 0) or_rise = cyc;

            case (md)
               M_IDLE: if (run) md = M_FETCH;
               M_FETCH: begin
                  if (imem_ack) begin
                     m_instr = imem_data;
                     m_pc    = m_pc + 8'd1;
                     md      = M_BUSY;
                     exec_at = -1; halt_at = -1; io_pend = 1'b0;
                     if (imem_data == 16'h0000) halt_at = cyc + 2;
                     else if (imem_data[15:8] == 8'hFE) exec_at = cyc + 2 + MW;
                     else if (imem_data[15:8] == 8'hFC || imem_data[15:8] == 8'hFD) begin
                        io_pend = 1'b1; io_from = cyc + 2;
                     end else exec_at = cyc + 2;
                  end
               end
               M_BUSY: begin
                  if (io_pend && cyc >= io_from &&
                      ((op == 8'hFC) ? in_valid : out_ready)) begin
                     exec_at = cyc + 1;
                     io_pend = 1'b0;
                  end
                  if (halt_at == cyc + 1) md = M_HALT;
                  else if (cyc == exec_at) begin
                     if (carryen) m_carry = carryout;
                     md = run ? M_FETCH : M_IDLE;
                  end
               end
               default: md = M_HALT;
            endcase
         end
      end
   end

   task automatic assert_reset();
      @(posedge clk);
      #1 rst_n = 1'b0;
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      clear_logs();
   endtask

   task automatic wait_halted(input int budget, input string name);
      int n = 0;
      while (!halted && n < budget) begin
         @(negedge clk);
         n++;
      end
      #1;
      chk(name, halted, 1);
   endtask

   function automatic logic [15:0] rand_instr();
      logic [7:0]  op;
      logic [15:0] w;
      case ($urandom_range(0, 7))
         0: op = 8'hF8;
         1: op = 8'hF9;
         2: op = 8'hFA;
         3: op = 8'hFB;
         4: op = 8'hFC;
         5: op = 8'hFD;
         6: op = 8'hFE;
         default: op = 8'h00;
      endcase
      if ($urandom_range(0, 3) == 0) op = 8'($urandom);
      w = {op, 8'($urandom)};
      if (w == 16'h0000) w = 16'h0001;
      return w;
   endfunction

   initial begin
      int n;
      int snap;
      rst_n = 1'b0;
      for (int a = 0; a < 256; a++) mem[a] = 16'hF800;

      // two plain instructions then HALT, zero-wait memory
      mem[0] = 16'hF800; mem[1] = 16'hF900; mem[2] = 16'h0000;
      repeat (2) @(posedge clk);
      #2;
      chk("por_imem_req", imem_req, 0);
      chk("por_halted", halted, 0);
      release_reset();
      wait_halted(60, "d1_halt_timeout");
      chk("d1_exec_count", exec_q.size(), 2);
      chk("d1_exec0_cycle", exec_q[0] - first_req, 2);
      chk("d1_exec1_cycle", exec_q[1] - first_req, 5);
      chk("d1_fetch_count", fetch_q.size(), 3);
      chk("d1_addr0", fetch_q[0], 0);
      chk("d1_addr1", fetch_q[1], 1);
      chk("d1_addr2", fetch_q[2], 2);
      snap = req_cnt;
      repeat (10) @(negedge clk);
      #1;
      chk("d1_no_req_after_halt", req_cnt, snap);
      chk("d1_still_halted", halted, 1);

      // multiply settle
      assert_reset();
      mem[0] = 16'hFE00; mem[1] = 16'h0000;
      release_reset();
      wait_halted(60, "d2_halt_timeout");
      chk("d2_exec_count", exec_q.size(), 1);
      chk("d2_mul_exec_cycle", exec_q[0] - first_req, 6);

      // input then output handshake waits
      assert_reset();
      f_in_valid = 1'b0; f_out_ready = 1'b0;
      mem[0] = 16'hFC00; mem[1] = 16'hFD00; mem[2] = 16'h0000;
      release_reset();
      repeat (10) @(negedge clk);
      @(posedge clk);
      f_in_valid = 1'b1;
      n = 0;
      while (exec_q.size() < 1 && n < 30) begin @(negedge clk); #1; n++; end
      repeat (5) @(negedge clk);
      @(posedge clk);
      f_out_ready = 1'b1;
      wait_halted(60, "d3_halt_timeout");
      chk("d3_exec_count", exec_q.size(), 2);
      chk("d3_in_ready_count", inrdy_q.size(), 1);
      chk("d3_in_ready_with_exec", inrdy_q[0], exec_q[0]);
      chk("d3_in_exec_after_valid", exec_q[0], iv_rise + 1);
      chk("d3_out_valid_count", ovld_q.size(), 1);
      chk("d3_out_valid_with_exec", ovld_q[0], exec_q[1]);
      chk("d3_out_exec_after_ready", exec_q[1], or_rise + 1);

      // carry written on first EXEC, held on the second
      assert_reset();
      f_carryen = 1'b1; f_carryout = 1'b1;
      mem[0] = 16'hF800; mem[1] = 16'hF900; mem[2] = 16'h0000;
      release_reset();
      #1;
      chk("d4_carry_after_reset", carrystatus, 0);
      n = 0;
      while (exec_q.size() < 1 && n < 30) begin @(posedge clk); n++; end
      f_carryen = 1'b0; f_carryout = 1'b0;
      wait_halted(60, "d4_halt_timeout");
      chk("d4_exec_count", exec_q.size(), 2);
      chk("d4_carry_held", carrystatus, 1);

      // PC wrap 0xFF -> 0x00, then HALT fetched at address 1 on the second pass
      assert_reset();
      for (int a = 0; a < 256; a++) mem[a] = 16'hFA00;
      release_reset();
      n = 0;
      while (fetch_q.size() < 3 && n < 30) begin @(negedge clk); #1; n++; end
      mem[1] = 16'h0000;
      wait_halted(1200, "d5_halt_timeout");
      chk("d5_fetch_count", fetch_q.size(), 258);
      chk("d5_addr_ff", fetch_q[255], 255);
      chk("d5_addr_wrap", fetch_q[256], 0);
      chk("d5_addr_halt", fetch_q[257], 1);

      // reset while a fetch is outstanding
      assert_reset();
      mem[0] = 16'hF800; mem[1] = 16'hF900;
      f_carryen = 1'b1; f_carryout = 1'b1;
      release_reset();
      n = 0;
      while (exec_q.size() < 1 && n < 30) begin @(negedge clk); #1; n++; end
      ack_pct = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("d6_req_held", imem_req, 1);
      chk("d6_addr_before", imem_addr, 1);
      chk("d6_carry_before", carrystatus, 1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      spur_pct = 100;
      #1;
      chk("d6_req_dropped", imem_req, 0);
      chk("d6_exec_dropped", exec1, 0);
      chk("d6_carry_cleared", carrystatus, 0);
      chk("d6_addr_cleared", imem_addr, 0);
      repeat (2) @(posedge clk);
      #1;
      spur_pct = 0; ack_pct = 100; f_carryen = 1'b0;
      release_reset();
      n = 0;
      while (fetch_q.size() < 1 && n < 30) begin @(negedge clk); #1; n++; end
      chk("d6_first_addr", fetch_q[0], 0);
      chk("d6_carry_after", carrystatus, 0);

      // randomized program and handshakes
      assert_reset();
      for (int a = 0; a < 256; a++) mem[a] = rand_instr();
      rand_mode = 1'b1; ack_pct = 60; spur_pct = 15;
      release_reset();
      repeat (4000) @(negedge clk);
      #1;
      chk("rand_progress", exec_q.size() > 200, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
